// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and block geometry for the cache miss fill controller.
package cache_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam int unsigned BLOCK_OFFSET_W  = 4;
  localparam int unsigned WORD_IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    TAG
  } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// Saturating word index counter with synchronous clear; done rises after the
// terminal count has been consumed and holds until the next clear.
module word_counter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [WORD_IDX_W-1:0] cnt_o,
  output logic                  done_o
);

  logic [WORD_IDX_W-1:0] cnt_q, cnt_d;
  logic                  done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (en_i && !done_q) begin
      if (cnt_q == '1) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    done_q <= done_d;
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: bursts 8 word reads for the missing block,
// streams returned words into the data array, then writes tag/valid last.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = 8,
  parameter int unsigned ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_data_valid,
  input  logic [ADDR_W-1:0] mem_data,
  output logic              fsm_busy,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic              load_data,
  output logic              load_tag,
  output logic [ADDR_W-1:0] cache_address,
  output logic [ADDR_W-1:0] cache_data,
  output logic              fill_done
);

  localparam int unsigned PAD_W = ADDR_W - WORD_IDX_W - 1;

  fill_state_t           state_q;
  logic [ADDR_W-1:0]     base_q;
  logic [WORD_IDX_W-1:0] req_cnt, resp_cnt;
  logic                  req_done, resp_done;
  logic                  in_fill, cnt_clr, last_resp;

  assign in_fill   = (state_q == FILL);
  assign cnt_clr   = rst || (state_q == IDLE);
  assign mem_enable = in_fill && !req_done;
  assign load_data  = in_fill && mem_data_valid && !resp_done;
  assign last_resp  = load_data && (resp_cnt == WORD_IDX_W'(WORDS_PER_BLOCK - 1));
  assign load_tag   = (state_q == TAG);
  assign fill_done  = load_tag;
  assign fsm_busy   = (state_q != IDLE) || miss_detected;

  word_counter u_req_cnt (
    .clk    (clk),
    .clr_i  (cnt_clr),
    .en_i   (mem_enable),
    .cnt_o  (req_cnt),
    .done_o (req_done)
  );

  word_counter u_resp_cnt (
    .clk    (clk),
    .clr_i  (cnt_clr),
    .en_i   (load_data),
    .cnt_o  (resp_cnt),
    .done_o (resp_done)
  );

  // Word offset is OR-ed into bits [3:1] only, so a fill never carries out of its block.
  always_comb begin
    mem_address   = '0;
    cache_address = '0;
    cache_data    = '0;
    if (mem_enable) begin
      mem_address = base_q | {{PAD_W{1'b0}}, req_cnt, 1'b0};
    end
    if (load_data) begin
      cache_address = base_q | {{PAD_W{1'b0}}, resp_cnt, 1'b0};
      cache_data    = mem_data;
    end else if (load_tag) begin
      cache_address = base_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            base_q  <= {miss_address[ADDR_W-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
            state_q <= FILL;
          end
        end
        FILL: begin
          if (last_resp) begin
            state_q <= TAG;
          end
        end
        TAG:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with hand-derived cycle-by-cycle expectations.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = 16'h0;
  logic        fsm_busy, mem_enable, load_data, load_tag, fill_done;
  logic [15:0] mem_address, cache_address, cache_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .miss_detected  (miss_detected),
    .miss_address   (miss_address),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data),
    .fsm_busy       (fsm_busy),
    .mem_enable     (mem_enable),
    .mem_address    (mem_address),
    .load_data      (load_data),
    .load_tag       (load_tag),
    .cache_address  (cache_address),
    .cache_data     (cache_data),
    .fill_done      (fill_done)
  );

  // Memory content model: each word address maps to a distinct data word.
  function automatic logic [15:0] word_of(logic [15:0] a);
    return (a * 16'd3) ^ 16'h5A5A;
  endfunction

  function automatic logic [52:0] obs_vec();
    return {fsm_busy, mem_enable, mem_address, load_data, load_tag,
            cache_address, cache_data, fill_done};
  endfunction

  // Expected outputs in cycle c of a fill whose miss was sampled at c=0, latency lat.
  function automatic logic [52:0] exp_fill(int c, logic [15:0] base, int lat, logic miss_now);
    logic        en, ld, tg;
    logic [15:0] ma, ca, cd;
    en = (c >= 1) && (c <= 8);
    ma = en ? base + 16'(2 * (c - 1)) : 16'h0;
    ld = (c >= 1 + lat) && (c <= 8 + lat);
    tg = (c == 9 + lat);
    ca = ld ? base + 16'(2 * (c - 1 - lat)) : (tg ? base : 16'h0);
    cd = ld ? word_of(ca) : 16'h0;
    return {((c <= 9 + lat) || miss_now), en, ma, ld, tg, ca, cd, tg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mem(int c, logic [15:0] base, int lat);
    mem_data_valid = (c >= 1 + lat) && (c <= 8 + lat);
    mem_data = mem_data_valid ? word_of(base + 16'(2 * (c - 1 - lat))) : 16'hBEEF;
  endtask

  task automatic run_fill(string name, logic [15:0] maddr, logic [15:0] base, int lat, int last_c);
    logic [52:0] e, o;
    for (int c = 0; c <= last_c; c++) begin
      miss_detected = (c == 0);
      miss_address  = (c == 0) ? maddr : 16'h0;
      drive_mem(c, base, lat);
      #2;
      e = exp_fill(c, base, lat, miss_detected);
      o = obs_vec();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s c=%0d got=%h exp=%h", name, c, o, e);
      end
      tick();
    end
    miss_detected  = 1'b0;
    mem_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #2;
    total++;
    if (obs_vec() !== 53'h0) begin
      bad++;
      $display("FAIL reset_idle got=%h exp=%h", obs_vec(), 53'h0);
    end
    miss_detected = 1'b1;
    miss_address  = 16'h7777;
    #1;
    total++;
    if (obs_vec() !== {1'b1, 52'h0}) begin
      bad++;
      $display("FAIL reset_busy_comb got=%h exp=%h", obs_vec(), {1'b1, 52'h0});
    end
    tick();
    rst            = 1'b0;
    miss_detected  = 1'b0;
    mem_data_valid = 1'b1;
    mem_data       = 16'h1234;
    #2;
    total++;
    if (obs_vec() !== 53'h0) begin
      bad++;
      $display("FAIL rst_wins_idle_valid got=%h exp=%h", obs_vec(), 53'h0);
    end
    tick();
    mem_data_valid = 1'b0;
  endtask

  task automatic test_single_fill();
    run_fill("single_fill", 16'h1236, 16'h1230, 4, 14);
  endtask

  task automatic test_gaps_and_spurious();
    logic [52:0] e, o;
    logic        vld, ld, tg, en;
    logic [15:0] ma, ca, cd;
    int          rcount = 0;
    for (int c = 0; c <= 16; c++) begin
      miss_detected  = (c <= 15);
      miss_address   = (c == 0) ? 16'h2008 : 16'h3330;
      vld            = (c == 5) || (c == 7) || (c == 8) || ((c >= 10) && (c <= 16));
      mem_data_valid = vld;
      mem_data       = word_of(16'h2000 + 16'(2 * rcount));
      #2;
      en = (c >= 1) && (c <= 8);
      ma = en ? 16'h2000 + 16'(2 * (c - 1)) : 16'h0;
      ld = vld && (c >= 1) && (rcount < 8);
      tg = (c == 15);
      ca = ld ? 16'h2000 + 16'(2 * rcount) : (tg ? 16'h2000 : 16'h0);
      cd = ld ? word_of(ca) : 16'h0;
      e  = {(c <= 15), en, ma, ld, tg, ca, cd, tg};
      o  = obs_vec();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL gap_fill c=%0d got=%h exp=%h", c, o, e);
      end
      if (ld) rcount++;
      tick();
    end
    miss_detected  = 1'b0;
    mem_data_valid = 1'b0;
  endtask

  task automatic test_wrap();
    run_fill("wrap_fill", 16'hFFFF, 16'hFFF0, 1, 11);
  endtask

  task automatic test_reset_mid_fill();
    logic [52:0] e, o;
    for (int c = 0; c <= 12; c++) begin
      rst           = (c == 7);
      miss_detected = (c == 0);
      miss_address  = (c == 0) ? 16'h5554 : 16'h0;
      drive_mem(c, 16'h5550, 4);
      #2;
      o = obs_vec();
      total++;
      if (c == 7) begin
        if (fsm_busy !== 1'b1) begin
          bad++;
          $display("FAIL abort_busy c=%0d got=%b exp=1", c, fsm_busy);
        end
      end else begin
        e = (c < 7) ? exp_fill(c, 16'h5550, 4, miss_detected) : 53'h0;
        if (o !== e) begin
          bad++;
          $display("FAIL abort_fill c=%0d got=%h exp=%h", c, o, e);
        end
      end
      tick();
    end
    rst            = 1'b0;
    mem_data_valid = 1'b0;
    run_fill("after_abort", 16'h0040, 16'h0040, 2, 12);
  endtask

  task automatic test_back_to_back();
    run_fill("b2b_first", 16'h0100, 16'h0100, 1, 10);
    run_fill("b2b_second", 16'h0210, 16'h0210, 1, 11);
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_gaps_and_spurious();
    test_wrap();
    test_reset_mid_fill();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
